// File: rtl/rsc_pkg.sv
// Shared definitions for the simple RISC CPU: opcode and condition encodings,
// memory command codes and the fetch-stage state enum.
package rsc_pkg;

    // Major opcodes, ir[15:13]
    localparam logic [2:0] OP_ALU    = 3'b101;
    localparam logic [2:0] OP_MOV    = 3'b110;
    localparam logic [2:0] OP_LDR    = 3'b011;
    localparam logic [2:0] OP_STR    = 3'b100;
    localparam logic [2:0] OP_BRANCH = 3'b001;
    localparam logic [2:0] OP_BLINK  = 3'b010;
    localparam logic [2:0] OP_HALT   = 3'b111;

    // Sub-operations of OP_BLINK, ir[12:11]; 2'b01 is not a link op and goes to the controller
    localparam logic [1:0] OPS_BX  = 2'b00;
    localparam logic [1:0] OPS_BLX = 2'b10;
    localparam logic [1:0] OPS_BL  = 2'b11;

    // Branch conditions, ir[10:8]; anything else is never taken
    localparam logic [2:0] COND_AL = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_NE = 3'b010;
    localparam logic [2:0] COND_LT = 3'b011;
    localparam logic [2:0] COND_LE = 3'b100;

    // Memory command codes
    localparam logic [1:0] MNONE = 2'b00;
    localparam logic [1:0] MREAD = 2'b01;

    typedef enum logic [2:0] {
        S_IF1,
        S_IF2,
        S_UPD,
        S_EXEC,
        S_HALT
    } fetch_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Evaluates a B-family condition code against the {N,V,Z} status flags.
module branch_cond_eval
    import rsc_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       taken
);

    logic flag_n;
    logic flag_v;
    logic flag_z;

    assign {flag_n, flag_v, flag_z} = flags;

    // Condition decode; reserved codes fall through to not-taken.
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_AL: taken = 1'b1;
            COND_EQ: taken = flag_z;
            COND_NE: taken = ~flag_z;
            COND_LT: taken = flag_n ^ flag_v;
            COND_LE: taken = (flag_n ^ flag_v) | flag_z;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_branch_unit.sv
// Fetch / PC stage: owns PC and IR, sequences fetch against the synchronous
// memory, resolves B, BL, BX and BLX locally and hands the rest to the controller.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IF1  | MREAD issued at pc
// S_IF2  | MREAD held, memory data captured into ir at cycle end
// S_UPD  | pc advances by one (wraps at 2^ADDR_W)
// S_EXEC | branch resolution, or waiting for exec_done from the controller
// S_HALT | terminal; only reset leaves this state
module fetch_branch_unit
    import rsc_pkg::*;
#(
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_cmd,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    input  logic              exec_done,
    input  logic [2:0]        flags,
    input  logic [DATA_W-1:0] rd_value,
    output logic              link_we,
    output logic [DATA_W-1:0] link_data,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;

    logic [2:0]        opcode;
    logic [1:0]        subop;
    logic [2:0]        cond;
    logic [ADDR_W-1:0] sximm8;
    logic [DATA_W-1:0] pc_ext;
    logic              br_taken;
    logic              unused_rd_hi;

    assign opcode = ir_q[15:13];
    assign subop  = ir_q[12:11];
    assign cond   = ir_q[10:8];
    assign sximm8 = {{(ADDR_W-8){ir_q[7]}}, ir_q[7:0]};
    assign pc_ext = {{(DATA_W-ADDR_W){1'b0}}, pc_q};

    // Only the low ADDR_W bits of R[Rd] form a jump target.
    assign unused_rd_hi = ^rd_value[DATA_W-1:ADDR_W];

    branch_cond_eval u_cond (
        .cond  (cond),
        .flags (flags),
        .taken (br_taken)
    );

    assign mem_addr = pc_q;
    assign pc       = pc_q;
    assign ir       = ir_q;
    assign halted   = (state_q == S_HALT);

    // State, PC and IR registers; reset aborts whatever is in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IF1;
            pc_q    <= ADDR_W'(RESET_PC);
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Fetch sequencing, branch resolution and controller handshake.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        mem_cmd   = MNONE;
        ir_valid  = 1'b0;
        link_we   = 1'b0;
        link_data = '0;
        unique case (state_q)
            S_IF1: begin
                mem_cmd = MREAD;
                state_d = S_IF2;
            end
            S_IF2: begin
                mem_cmd = MREAD;
                ir_d    = mem_rdata;
                state_d = S_UPD;
            end
            S_UPD: begin
                pc_d    = pc_q + PC_ONE;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (opcode == OP_BRANCH) begin
                    if (br_taken) begin
                        pc_d = pc_q + sximm8;
                    end
                    state_d = S_IF1;
                end else if (opcode == OP_BLINK && subop == OPS_BL) begin
                    link_we   = 1'b1;
                    link_data = pc_ext;
                    pc_d      = pc_q + sximm8;
                    state_d   = S_IF1;
                end else if (opcode == OP_BLINK && (subop == OPS_BX || subop == OPS_BLX)) begin
                    // Controller reads Rd for us; the link write shares the
                    // exec_done cycle so BLX R7 sees the old R7.
                    ir_valid = 1'b1;
                    if (exec_done) begin
                        pc_d    = rd_value[ADDR_W-1:0];
                        state_d = S_IF1;
                        if (subop == OPS_BLX) begin
                            link_we   = 1'b1;
                            link_data = pc_ext;
                        end
                    end
                end else if (opcode == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    ir_valid = 1'b1;
                    if (exec_done) begin
                        state_d = S_IF1;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IF1;
            end
        endcase
    end

endmodule
